// File: rtl/lanzones_pkg.sv
`default_nettype none
// lanzones_pkg: shared fetch-path defaults, fetch entry type and RV32I major opcodes.
package lanzones_pkg;

   localparam int unsigned          XLEN_DEF     = 32;
   localparam logic [XLEN_DEF-1:0]  RESET_PC_DEF = '0;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] inst;
   } fetch_entry_t;

   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_OPIMM   = 7'b0010011;
   localparam logic [6:0] OP_OP      = 7'b0110011;
   localparam logic [6:0] OP_MISCMEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

endpackage
`default_nettype wire

// File: rtl/lanzones_sync_fifo.sv
`default_nettype none
// lanzones_sync_fifo: power-of-2 synchronous FIFO with flush taking priority over push/pop.
module lanzones_sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/lanzones_fetch_queue.sv
`default_nettype none
// lanzones_fetch_queue: pipelined in-order instruction fetch with credit-limited prefetch queue
// and redirect flush that drops every response still in flight.
module lanzones_fetch_queue
   import lanzones_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEF,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
   parameter int unsigned      PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            en,
   output logic            req_vld,
   input  logic            req_rdy,
   output logic [XLEN-1:0] req_addr,
   input  logic            rsp_vld,
   input  logic [XLEN-1:0] rsp_data,
   input  logic            redirect_vld,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_vld,
   input  logic            inst_rdy,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic            err
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned SW = CW + 2;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic            req_vld_q, req_vld_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic            err_q, err_d;

   logic            fire, rsp_ok, can_issue, push, pop;
   logic [SW-1:0]   credit_used;
   logic [CW-1:0]   fifo_count;
   logic            fifo_empty, fifo_full;
   logic [2*XLEN-1:0] fifo_head;

   assign fire        = req_vld_q && req_rdy;
   assign rsp_ok      = rsp_vld && (outstanding_q != '0);
   // Queued + outstanding + the request on the bus bounds future queue occupancy.
   assign credit_used = SW'(fifo_count) + SW'(outstanding_q) + SW'(req_vld_q);
   assign can_issue   = en && (credit_used < SW'(DEPTH)) && !redirect_vld;
   assign push        = rsp_ok && (drop_q == '0) && !redirect_vld && !fifo_full;
   assign pop         = inst_vld && inst_rdy && !redirect_vld;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_d        = drop_q;
      err_d         = err_q || (rsp_vld && (outstanding_q == '0));
      outstanding_d = outstanding_q + CW'(fire) - CW'(rsp_ok);

      if (redirect_vld)               req_vld_d = 1'b0;
      else if (req_vld_q && !req_rdy) req_vld_d = 1'b1;
      else                            req_vld_d = can_issue;

      if (redirect_vld) begin
         // Anything still owed by memory, including a request accepted this cycle, is stale.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_d     = outstanding_d;
      end else begin
         if (fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
         if (rsp_ok) begin
            if (drop_q != '0) drop_d   = drop_q - CW'(1);
            else              rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         req_vld_q     <= 1'b0;
         outstanding_q <= '0;
         drop_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         req_vld_q     <= req_vld_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         err_q         <= err_d;
      end
   end

   lanzones_sync_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (redirect_vld),
      .push_i  (push),
      .data_i  ({rsp_pc_q, rsp_data}),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign req_vld   = req_vld_q;
   assign req_addr  = fetch_pc_q;
   assign inst_vld  = !fifo_empty;
   assign inst_pc   = fifo_head[2*XLEN-1:XLEN];
   assign inst_data = fifo_head[XLEN-1:0];
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lanzones_fetch_queue.sv
`default_nettype none
// tb_lanzones_fetch_queue: randomized traffic against a queue-based reference of the fetch front end.
module tb_lanzones_fetch_queue;
   import lanzones_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned PC_STEP  = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0, req_rdy = 1'b0, rsp_vld = 1'b0, redirect_vld = 1'b0, inst_rdy = 1'b0;
   logic [31:0] rsp_data = '0, redirect_pc = '0;
   logic        req_vld, inst_vld, err;
   logic [31:0] req_addr, inst_data, inst_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: what the front end must look like after each edge.
   logic [31:0] m_fetch, m_rsp;
   bit          m_reqv, m_err;
   int          m_out, m_drop;
   logic [63:0] m_q [$];
   // Memory model: accepted addresses with the cycle their response is due.
   logic [31:0] mem_addr [$];
   int          mem_due [$];
   int          cyc, last_due, dut_fires;

   always #5 clk = ~clk;

   lanzones_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .en           (en),
      .req_vld      (req_vld),
      .req_rdy      (req_rdy),
      .req_addr     (req_addr),
      .rsp_vld      (rsp_vld),
      .rsp_data     (rsp_data),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .inst_vld     (inst_vld),
      .inst_rdy     (inst_rdy),
      .inst_data    (inst_data),
      .inst_pc      (inst_pc),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h37;
   endfunction

   task automatic model_reset();
      m_fetch  = RESET_PC;
      m_rsp    = RESET_PC;
      m_reqv   = 1'b0;
      m_err    = 1'b0;
      m_out    = 0;
      m_drop   = 0;
      last_due = 0;
      m_q.delete();
      mem_addr.delete();
      mem_due.delete();
   endtask

   task automatic check_outputs();
      chk("req_vld", req_vld, m_reqv);
      if (m_reqv) chk("req_addr", req_addr, m_fetch);
      chk("inst_vld", inst_vld, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("inst_pc", inst_pc, m_q[0][63:32]);
         chk("inst_data", inst_data, m_q[0][31:0]);
      end
      chk("err", err, m_err);
   endtask

   task automatic model_update(input int latlo, input int lathi);
      bit fire, pop, ok, nr;
      int out_n, due;
      fire  = m_reqv && req_rdy;
      pop   = (m_q.size() != 0) && inst_rdy && !redirect_vld;
      ok    = rsp_vld && (m_out > 0);
      if (rsp_vld && m_out == 0) m_err = 1'b1;
      out_n = m_out + int'(fire) - int'(ok);
      if (redirect_vld)            nr = 1'b0;
      else if (m_reqv && !req_rdy) nr = 1'b1;
      else nr = en && ((m_q.size() + m_out + int'(m_reqv)) < DEPTH);
      if (fire) begin
         due = cyc + int'($urandom_range(lathi, latlo)) - 1;
         if (due < last_due) due = last_due;
         last_due = due;
         mem_addr.push_back(m_fetch);
         mem_due.push_back(due);
      end
      if (redirect_vld) begin
         m_q.delete();
         m_fetch = redirect_pc;
         m_rsp   = redirect_pc;
         m_drop  = out_n;
      end else begin
         if (fire) m_fetch += PC_STEP;
         if (pop) void'(m_q.pop_front());
         if (ok) begin
            if (m_drop > 0) m_drop--;
            else begin
               m_q.push_back({m_rsp, rsp_data});
               m_rsp += PC_STEP;
            end
         end
      end
      m_reqv = nr;
      m_out  = out_n;
   endtask

   // One clock: check, drive (percent knobs; redirect in per-mille), advance the reference.
   task automatic step(input int pen, input int prdy, input int pirdy, input int predir,
                       input int latlo, input int lathi, input bit spur);
      bit dut_rv;
      @(negedge clk);
      check_outputs();
      dut_rv       = req_vld;
      en           = ($urandom_range(99) < pen);
      req_rdy      = ($urandom_range(99) < prdy);
      inst_rdy     = ($urandom_range(99) < pirdy);
      redirect_vld = ($urandom_range(999) < predir);
      redirect_pc  = $urandom & 32'hFFFF_FFFC;
      rsp_data     = $urandom;
      if (mem_due.size() != 0 && mem_due[0] <= cyc) begin
         rsp_vld  = 1'b1;
         rsp_data = mem_word(mem_addr[0]);
         void'(mem_due.pop_front());
         void'(mem_addr.pop_front());
      end else begin
         rsp_vld = spur;
      end
      if (dut_rv && req_rdy) dut_fires++;
      @(posedge clk);
      cyc++;
      model_update(latlo, lathi);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn         = 1'b0;
      en           = 1'b1;
      req_rdy      = 1'b1;
      rsp_vld      = 1'b1;
      rsp_data     = $urandom;
      redirect_vld = 1'b0;
      inst_rdy     = 1'b1;
      @(posedge clk);
      cyc++;
      model_reset();
      @(negedge clk);
      chk("rst_req_vld", req_vld, 1'b0);
      chk("rst_req_addr", req_addr, RESET_PC);
      chk("rst_inst_vld", inst_vld, 1'b0);
      chk("rst_err", err, 1'b0);
      rstn     = 1'b1;
      en       = 1'b0;
      req_rdy  = 1'b0;
      rsp_vld  = 1'b0;
      inst_rdy = 1'b0;
   endtask

   initial begin
      cyc       = 0;
      dut_fires = 0;
      model_reset();
      do_reset();

      // Streaming with fixed 2-cycle memory latency.
      repeat (40) step(100, 100, 100, 0, 2, 2, 1'b0);

      // Decode stalled: exactly DEPTH requests go out, head stays at the reset PC.
      do_reset();
      dut_fires = 0;
      repeat (20) step(100, 100, 0, 0, 1, 3, 1'b0);
      #1;
      chk("bp_fires", 64'(dut_fires), 64'(DEPTH));
      chk("bp_head_data", inst_data, {25'h0, OP_LUI});
      chk("bp_head_pc", inst_pc, RESET_PC);
      repeat (20) step(100, 100, 100, 0, 1, 3, 1'b0);

      // Mixed random traffic: general, slow memory, redirect-heavy.
      repeat (3000) step(70, 60, 60, 40, 1, 4, 1'b0);
      repeat (800)  step(90, 20, 80, 15, 1, 3, 1'b0);
      repeat (800)  step(80, 80, 50, 200, 1, 3, 1'b0);

      // Reset while traffic is in flight.
      do_reset();

      // Spurious response with nothing outstanding.
      repeat (3) step(0, 100, 100, 0, 1, 1, 1'b0);
      step(0, 100, 100, 0, 1, 1, 1'b1);
      #1;
      chk("err_set", err, 1'b1);
      chk("err_nopush", inst_vld, 1'b0);
      repeat (30) step(80, 80, 80, 20, 1, 3, 1'b0);
      do_reset();
      repeat (5) step(100, 100, 100, 0, 1, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
